// File: rtl/bcd_display_mux.sv
// Time-multiplexed common-anode 7-segment driver for an N-digit BCD sum plus carry.
// Latches sum/carry on load; scans N+1 positions with leading-zero blanking and a frame pulse.
module bcd_display_mux #(
   parameter int unsigned N        = 4,
   parameter int unsigned PRESCALE = 100000
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           load,
   input  logic [4*N-1:0] sum,
   input  logic           c_out,
   output logic [N:0]     an,
   output logic [6:0]     seg,
   output logic           frame
);

   localparam int unsigned KW = $clog2(N + 1);
   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [KW-1:0] KLast = KW'(N);
   localparam logic [PW-1:0] PLast = PW'(PRESCALE - 1);

   localparam logic [6:0] SegBlank = 7'b1111111;
   localparam logic [6:0] SegDash  = 7'b0111111;
   localparam logic [6:0] SegOne   = 7'b1111001;

   logic [4*N-1:0] d_q, d_d;
   logic           c_q, c_d;
   logic [PW-1:0]  p_q, p_d;
   logic [KW-1:0]  k_q, k_d;
   logic [N:0]     an_q, an_d;
   logic [6:0]     seg_q, seg_d;
   logic           frame_q, frame_d;

   logic [N-1:0]   blank_vec;
   logic           zero_run;
   logic [3:0]     nib;
   logic           blk;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      unique case (v)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SegDash;
      endcase
      return s;
   endfunction

   always_comb begin
      p_d = p_q + 1'b1;
      k_d = k_q;
      if (p_q == PLast) begin
         p_d = '0;
         k_d = (k_q == KLast) ? '0 : k_q + 1'b1;
      end
      d_d = load ? sum : d_q;
      c_d = load ? c_out : c_q;
   end

   always_comb begin
      // Walk from the MSB down; a digit stays blank while everything above it (carry included) is zero.
      blank_vec = '0;
      zero_run  = ~c_q;
      for (int i = N - 1; i >= 0; i--) begin
         zero_run     = zero_run & (d_q[4*i +: 4] == 4'd0);
         blank_vec[i] = zero_run;
      end
      blank_vec[0] = 1'b0;

      nib = 4'd0;
      blk = 1'b0;
      an_d = '1;
      for (int i = 0; i <= N; i++) begin
         an_d[i] = (k_q != KW'(i));
      end
      for (int i = 0; i < N; i++) begin
         if (k_q == KW'(i)) begin
            nib = d_q[4*i +: 4];
            blk = blank_vec[i];
         end
      end

      if (k_q == KLast) begin
         seg_d = c_q ? SegOne : SegBlank;
      end else begin
         seg_d = blk ? SegBlank : decode(nib);
      end

      // an_q[N] low means the outputs currently show the carry position; reset state never pulses.
      frame_d = (k_q == '0) && !an_q[N];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d_q     <= '0;
         c_q     <= 1'b0;
         p_q     <= '0;
         k_q     <= '0;
         an_q    <= '1;
         seg_q   <= SegBlank;
         frame_q <= 1'b0;
      end else begin
         d_q     <= d_d;
         c_q     <= c_d;
         p_q     <= p_d;
         k_q     <= k_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         frame_q <= frame_d;
      end
   end

   assign an    = an_q;
   assign seg   = seg_q;
   assign frame = frame_q;

endmodule
